melody_sequencer: RTL and testbench

Plays a fixed melody through the note generator by driving its 6-bit note/waveform select word, one ROM entry at a time, for a programmable number of beats each. Sits between the board control logic (buttons/switches) and the note selector. A start pulse launches the song and a stop pulse aborts it. The block optionally loops the song and reports progress and completion for display logic.

---
 rtl/melody_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a fixed note ROM, holding each entry's {wave, note} for dur beats.
// Build macro MELODY_GAP_EN mutes the last BEAT_CYCLES/8 cycles of every note for articulation.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned SONG_LEN    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic       wave_sel,
    output logic [5:0] select,
    output logic       mute,
    output logic       busy,
    output logic [4:0] step,
    output logic       done,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    localparam logic [4:0]  REST_NOTE = 5'd31;
    localparam logic [5:0]  SONG_END  = 6'(SONG_LEN);
    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
`ifdef MELODY_GAP_EN
    localparam logic [31:0] GAP_START = 32'(BEAT_CYCLES - BEAT_CYCLES / 8);
`endif

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [5:0]  select_q, select_d;
    logic        mute_q, mute_d;
    logic        busy_q, busy_d;
    logic [4:0]  step_q, step_d;
    logic        done_q, done_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [2:0]  beats_left_q, beats_left_d;
    logic        rest_q, rest_d;

    logic [7:0]  rom_word;
    logic [4:0]  rom_note;
    logic [2:0]  rom_dur;
    logic        song_end;

    // ROM entry layout is {note[4:0], dur[2:0]}; dur 0 marks the end of the song.
    always_comb begin
        case (addr_q)
            6'd0:    rom_word = {5'd0,  3'd1};
            6'd1:    rom_word = {5'd2,  3'd1};
            6'd2:    rom_word = {5'd4,  3'd1};
            6'd3:    rom_word = {5'd5,  3'd1};
            6'd4:    rom_word = {5'd7,  3'd1};
            6'd5:    rom_word = {5'd9,  3'd1};
            6'd6:    rom_word = {5'd11, 3'd1};
            6'd7:    rom_word = {5'd12, 3'd1};
            6'd8:    rom_word = {REST_NOTE, 3'd2};
            6'd9:    rom_word = {5'd12, 3'd4};
            default: rom_word = 8'h00;
        endcase
    end

    assign rom_note = rom_word[7:3];
    assign rom_dur  = rom_word[2:0];
    assign song_end = (rom_dur == 3'd0) || (addr_q >= SONG_END);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        select_d     = select_q;
        mute_d       = mute_q;
        busy_d       = busy_q;
        step_d       = step_q;
        done_d       = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        beats_left_d = beats_left_q;
        rest_d       = rest_q;

        // stop overrides everything, including a simultaneous start
        if (stop) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            mute_d       = 1'b1;
            busy_d       = 1'b0;
            beat_cnt_d   = '0;
            beats_left_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mute_d = 1'b1;
                    busy_d = 1'b0;
                    if (start) begin
                        state_d = S_FETCH;
                        addr_d  = '0;
                        busy_d  = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!song_end) begin
                        state_d      = S_PLAY;
                        select_d     = {wave_sel, rom_note};
                        step_d       = addr_q[4:0];
                        beat_cnt_d   = '0;
                        beats_left_d = rom_dur;
                        rest_d       = (rom_note == REST_NOTE);
                        mute_d       = (rom_note == REST_NOTE);
                    end else if (loop_en) begin
                        addr_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        busy_d  = 1'b0;
                        mute_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
                S_PLAY: begin
                    mute_d = rest_q;
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d   = '0;
                        beats_left_d = beats_left_q - 3'd1;
                        if (beats_left_q == 3'd1) begin
                            state_d = S_FETCH;
                            addr_d  = addr_q + 6'd1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

`ifdef MELODY_GAP_EN
        // mute is registered, so the gap is decided from the counter values about to be loaded
        if (state_d == S_PLAY) begin
            mute_d = rest_d || ((beats_left_d == 3'd1) && (beat_cnt_d >= GAP_START));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            select_q     <= '0;
            mute_q       <= 1'b1;
            busy_q       <= 1'b0;
            step_q       <= '0;
            done_q       <= 1'b0;
            beat_cnt_q   <= '0;
            beats_left_q <= '0;
            rest_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            select_q     <= select_d;
            mute_q       <= mute_d;
            busy_q       <= busy_d;
            step_q       <= step_d;
            done_q       <= done_d;
            beat_cnt_q   <= beat_cnt_d;
            beats_left_q <= beats_left_d;
            rest_q       <= rest_d;
        end
    end

    assign select      = select_q;
    assign mute        = mute_q;
    assign busy        = busy_q;
    assign step        = step_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_CYCLES=8, SONG_LEN=16.
// Edge index e=1 is the first rising edge that samples start (state becomes FETCH).
module tb_melody_sequencer;
    localparam int BEAT = 8;
    localparam int LEN  = 16;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
`ifdef MELODY_GAP_EN
    localparam logic GAP = 1'b1;
`else
    localparam logic GAP = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       loop_en  = 1'b0;
    logic       wave_sel = 1'b0;
    logic [5:0] select;
    logic       mute;
    logic       busy;
    logic [4:0] step;
    logic       done;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    melody_sequencer #(.BEAT_CYCLES(BEAT), .SONG_LEN(LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .wave_sel   (wave_sel),
        .select     (select),
        .mute       (mute),
        .busy       (busy),
        .step       (step),
        .done       (done),
        .dbg_state_o(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after e=1.
    task automatic launch(input logic loop, input logic wave);
        loop_en  = loop;
        wave_sel = wave;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    initial begin
        int done_e;
        int done_n;
        int rest_mute;
        int e9_cnt;
        logic busy_at_done;

        // reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_select", 32'(select), 32'h00);
        check_eq("rst_mute",   32'(mute),   32'd1);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_step",   32'(step),   32'd0);
        check_eq("rst_done",   32'(done),   32'd0);
        check_eq("rst_state",  32'(dbg_state), 32'(ST_IDLE));

        // full song, no loop; wave_sel toggled mid-note, start while busy ignored
        done_e = 0; done_n = 0; rest_mute = 0; e9_cnt = 0; busy_at_done = 1'b1;
        launch(1'b0, 1'b0);
        for (int e = 1; e <= 130; e++) begin
            if (e > 1) @(negedge clk);
            start = 1'b0;
            case (e)
                1: begin
                    check_eq("s_fetch_state", 32'(dbg_state), 32'(ST_FETCH));
                    check_eq("s_fetch_busy",  32'(busy), 32'd1);
                end
                2: begin
                    check_eq("s_e0_select", 32'(select), 32'h00);
                    check_eq("s_e0_step",   32'(step),   32'd0);
                    check_eq("s_e0_state",  32'(dbg_state), 32'(ST_PLAY));
                end
                11: begin
                    check_eq("s_e1_select", 32'(select), 32'h02);
                    check_eq("s_e1_step",   32'(step),   32'd1);
                    check_eq("s_e1_mute",   32'(mute),   32'd0);
                end
                15: wave_sel = 1'b1;
                19: check_eq("s_wave_hold", 32'(select), 32'h02);
                20: begin
                    check_eq("s_e2_select", 32'(select), 32'h24);
                    check_eq("s_e2_step",   32'(step),   32'd2);
                end
                25: wave_sel = 1'b0;
                29: begin
                    check_eq("s_e3_select", 32'(select), 32'h05);
                    check_eq("s_e3_step",   32'(step),   32'd3);
                end
                40: start = 1'b1;
                45: begin
                    check_eq("s_busy_start_step",  32'(step), 32'd4);
                    check_eq("s_busy_start_state", 32'(dbg_state), 32'(ST_PLAY));
                end
                74: begin
                    check_eq("s_rest_select", 32'(select), 32'h1F);
                    check_eq("s_rest_step",   32'(step),   32'd8);
                    check_eq("s_rest_mute",   32'(mute),   32'd1);
                end
                91: begin
                    check_eq("s_e9_select", 32'(select), 32'h0C);
                    check_eq("s_e9_step",   32'(step),   32'd9);
                    check_eq("s_e9_mute",   32'(mute),   32'd0);
                end
                default: ;
            endcase
            if (e >= 2 && e <= 9)
                check_eq("s_e0_gap_mute", 32'(mute), 32'(GAP && (e == 9)));
            if (dbg_state == ST_PLAY && step == 5'd8 && mute) rest_mute++;
            if (dbg_state == ST_PLAY && step == 5'd9 && select == 6'h0C) e9_cnt++;
            if (done) begin
                done_n++;
                if (done_e == 0) begin
                    done_e       = e;
                    busy_at_done = busy;
                end
            end
        end
        check_eq("s_done_edge",    32'(done_e), 32'd124);
        check_eq("s_done_count",   32'(done_n), 32'd1);
        check_eq("s_busy_at_done", 32'(busy_at_done), 32'd0);
        check_eq("s_rest_cycles",  32'(rest_mute), 32'd16);
        check_eq("s_e9_cycles",    32'(e9_cnt), 32'd32);
        check_eq("s_end_state",    32'(dbg_state), 32'(ST_IDLE));
        check_eq("s_end_mute",     32'(mute), 32'd1);

        // looping with triangle waveform
        done_n = 0;
        launch(1'b1, 1'b1);
        for (int e = 1; e <= 130; e++) begin
            if (e > 1) @(negedge clk);
            case (e)
                2:   check_eq("l_e0_select", 32'(select), 32'h20);
                123: begin
                    check_eq("l_end_state",  32'(dbg_state), 32'(ST_FETCH));
                    check_eq("l_end_select", 32'(select), 32'h2C);
                end
                124: begin
                    check_eq("l_wrap_state", 32'(dbg_state), 32'(ST_FETCH));
                    check_eq("l_wrap_busy",  32'(busy), 32'd1);
                end
                125: begin
                    check_eq("l_replay_select", 32'(select), 32'h20);
                    check_eq("l_replay_step",   32'(step),   32'd0);
                    check_eq("l_replay_mute",   32'(mute),   32'd0);
                    check_eq("l_replay_state",  32'(dbg_state), 32'(ST_PLAY));
                end
                default: ;
            endcase
            if (done) done_n++;
        end
        check_eq("l_no_done", 32'(done_n), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("l_stop_state",  32'(dbg_state), 32'(ST_IDLE));
        check_eq("l_stop_busy",   32'(busy), 32'd0);
        check_eq("l_stop_mute",   32'(mute), 32'd1);
        check_eq("l_stop_select", 32'(select), 32'h20);

        // stop and start together while playing entry 3
        done_n = 0;
        launch(1'b0, 1'b0);
        for (int e = 1; e <= 40; e++) begin
            if (e > 1) @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            case (e)
                31: begin
                    check_eq("x_pre_step", 32'(step), 32'd3);
                    start = 1'b1;
                    stop  = 1'b1;
                end
                32: begin
                    check_eq("x_state",  32'(dbg_state), 32'(ST_IDLE));
                    check_eq("x_mute",   32'(mute),   32'd1);
                    check_eq("x_busy",   32'(busy),   32'd0);
                    check_eq("x_step",   32'(step),   32'd3);
                    check_eq("x_select", 32'(select), 32'h05);
                end
                40: check_eq("x_still_idle", 32'(dbg_state), 32'(ST_IDLE));
                default: ;
            endcase
            if (done) done_n++;
        end
        check_eq("x_no_done", 32'(done_n), 32'd0);

        // reset in the middle of entry 1
        launch(1'b0, 1'b1);
        for (int e = 1; e <= 16; e++) begin
            if (e > 1) @(negedge clk);
            reset = 1'b0;
            case (e)
                13: begin
                    check_eq("r_pre_select", 32'(select), 32'h22);
                    reset = 1'b1;
                end
                14: begin
                    check_eq("r_select", 32'(select), 32'h00);
                    check_eq("r_mute",   32'(mute),   32'd1);
                    check_eq("r_busy",   32'(busy),   32'd0);
                    check_eq("r_step",   32'(step),   32'd0);
                    check_eq("r_done",   32'(done),   32'd0);
                end
                16: check_eq("r_state", 32'(dbg_state), 32'(ST_IDLE));
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
